// File: rtl/bht_1bit_table.sv
// ---------------------------------------------------------------------------
// bht_1bit_table
//
// Branch history table of 1-bit predictors. Each entry holds one direction
// bit (st) and one valid bit (v), all in flops. The IF stage gets a
// registered prediction one cycle after a lookup. The EX stage writes back
// resolved outcomes.
//
// Optional build macro: BHT_STATS_EN
//   defined   : saturating update and mispredict counters are built
//   undefined : MISS_COUNT / UPD_COUNT are tied to 0 and MISS is unused
//
// Ports
//   CLK             in   system clock, rising edge
//   RESET           in   synchronous active-high reset
//   PRED_VALID      in   lookup request
//   PRED_ADDR       in   lookup index [IDX_W-1:0]
//   PRED_OUT_VALID  out  registered lookup-result valid
//   PREDICTION      out  registered prediction, 1 = taken
//   PRED_HIT        out  registered valid bit of the looked-up entry
//   UPD_VALID       in   resolved-branch update strobe
//   UPD_ADDR        in   update index [IDX_W-1:0]
//   OUTCOME         in   resolved direction, 1 = taken
//   MISS            in   resolved branch was mispredicted
//   INVALIDATE      in   clear every valid bit
//   MISS_COUNT      out  mispredict counter [CNT_W-1:0]
//   UPD_COUNT       out  update counter [CNT_W-1:0]
// ---------------------------------------------------------------------------
module bht_1bit_table #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PRED_VALID,
    input  logic [IDX_W-1:0] PRED_ADDR,
    output logic             PRED_OUT_VALID,
    output logic             PREDICTION,
    output logic             PRED_HIT,
    input  logic             UPD_VALID,
    input  logic [IDX_W-1:0] UPD_ADDR,
    input  logic             OUTCOME,
    input  logic             MISS,
    input  logic             INVALIDATE,
    output logic [CNT_W-1:0] MISS_COUNT,
    output logic [CNT_W-1:0] UPD_COUNT
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] st_q, st_d;
    logic [DEPTH-1:0] v_q, v_d;
    logic             pred_out_valid_q, pred_out_valid_d;
    logic             prediction_q, prediction_d;
    logic             pred_hit_q, pred_hit_d;
    logic             bypass;

    assign bypass = PRED_VALID && UPD_VALID && (PRED_ADDR == UPD_ADDR);

    // Table state: invalidate first, then the update overrides its own entry
    // so a simultaneous update survives the bulk clear.
    always_comb begin
        st_d = st_q;
        v_d  = v_q;
        if (INVALIDATE) begin
            v_d = '0;
        end
        if (UPD_VALID) begin
            st_d[UPD_ADDR] = OUTCOME;
            v_d[UPD_ADDR]  = 1'b1;
        end
    end

    // Lookup reads pre-update state; the bypass forwards the in-flight
    // outcome when both ports target the same entry.
    always_comb begin
        pred_out_valid_d = PRED_VALID;
        prediction_d     = prediction_q;
        pred_hit_d       = pred_hit_q;
        if (PRED_VALID) begin
            if (bypass) begin
                prediction_d = OUTCOME;
                pred_hit_d   = 1'b1;
            end else begin
                prediction_d = v_q[PRED_ADDR] & st_q[PRED_ADDR];
                pred_hit_d   = v_q[PRED_ADDR];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            st_q             <= '0;
            v_q              <= '0;
            pred_out_valid_q <= 1'b0;
            prediction_q     <= 1'b0;
            pred_hit_q       <= 1'b0;
        end else begin
            st_q             <= st_d;
            v_q              <= v_d;
            pred_out_valid_q <= pred_out_valid_d;
            prediction_q     <= prediction_d;
            pred_hit_q       <= pred_hit_d;
        end
    end

    assign PRED_OUT_VALID = pred_out_valid_q;
    assign PREDICTION     = prediction_q;
    assign PRED_HIT       = pred_hit_q;

`ifdef BHT_STATS_EN
    logic [CNT_W-1:0] upd_count_q, upd_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        upd_count_d  = upd_count_q;
        miss_count_d = miss_count_q;
        if (UPD_VALID && (upd_count_q != {CNT_W{1'b1}})) begin
            upd_count_d = upd_count_q + 1'b1;
        end
        if (UPD_VALID && MISS && (miss_count_q != {CNT_W{1'b1}})) begin
            miss_count_d = miss_count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            upd_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            upd_count_q  <= upd_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign UPD_COUNT  = upd_count_q;
    assign MISS_COUNT = miss_count_q;
`else
    // MISS only feeds the statistics, which are not built here.
    logic unused_miss;
    assign unused_miss = MISS;

    assign UPD_COUNT  = '0;
    assign MISS_COUNT = '0;
`endif

endmodule

// File: tb/tb_bht_1bit_table.sv
module tb_bht_1bit_table;

    localparam int IDX_W = 3;
    localparam int DEPTH = 1 << IDX_W;
`ifdef BHT_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic             CLK;
    logic             RESET;
    logic             PRED_VALID;
    logic [IDX_W-1:0] PRED_ADDR;
    logic             PRED_OUT_VALID;
    logic             PREDICTION;
    logic             PRED_HIT;
    logic             UPD_VALID;
    logic [IDX_W-1:0] UPD_ADDR;
    logic             OUTCOME;
    logic             MISS;
    logic             INVALIDATE;
    logic [CNT_W-1:0] MISS_COUNT;
    logic [CNT_W-1:0] UPD_COUNT;

    int checks = 0;
    int errors = 0;

    // Reference model: per-entry direction and valid, expected registered
    // outputs, and expected counters.
    bit               m_st [DEPTH];
    bit               m_v  [DEPTH];
    logic [2:0]       m_out;
    logic [CNT_W-1:0] m_upd;
    logic [CNT_W-1:0] m_miss;

    bht_1bit_table #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .PRED_VALID     (PRED_VALID),
        .PRED_ADDR      (PRED_ADDR),
        .PRED_OUT_VALID (PRED_OUT_VALID),
        .PREDICTION     (PREDICTION),
        .PRED_HIT       (PRED_HIT),
        .UPD_VALID      (UPD_VALID),
        .UPD_ADDR       (UPD_ADDR),
        .OUTCOME        (OUTCOME),
        .MISS           (MISS),
        .INVALIDATE     (INVALIDATE),
        .MISS_COUNT     (MISS_COUNT),
        .UPD_COUNT      (UPD_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, advance the model, and return 1 time unit
    // after the sampling edge.
    task automatic step(input logic rst, input logic pv, input int pa,
                        input logic uv, input int ua, input logic oc,
                        input logic ms, input logic inv);
        RESET      = rst;
        PRED_VALID = pv;
        PRED_ADDR  = pa[IDX_W-1:0];
        UPD_VALID  = uv;
        UPD_ADDR   = ua[IDX_W-1:0];
        OUTCOME    = oc;
        MISS       = ms;
        INVALIDATE = inv;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_st[i] = 1'b0;
                m_v[i]  = 1'b0;
            end
            m_out  = 3'b000;
            m_upd  = '0;
            m_miss = '0;
        end else begin
            m_out[2] = pv;
            if (pv) begin
                if (uv && (pa % DEPTH) == (ua % DEPTH)) begin
                    m_out[1:0] = {oc, 1'b1};
                end else begin
                    m_out[1] = m_v[pa % DEPTH] && m_st[pa % DEPTH];
                    m_out[0] = m_v[pa % DEPTH];
                end
            end
            if (inv) begin
                for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
            end
            if (uv) begin
                m_st[ua % DEPTH] = oc;
                m_v[ua % DEPTH]  = 1'b1;
`ifdef BHT_STATS_EN
                if (m_upd != {CNT_W{1'b1}}) m_upd = m_upd + 1'b1;
                if (ms && m_miss != {CNT_W{1'b1}}) m_miss = m_miss + 1'b1;
`endif
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
        checks++;
        if (UPD_COUNT !== '0 || MISS_COUNT !== '0) begin
            errors++;
            $display("FAIL reset_counters got upd=%0d miss=%0d want 0 0", UPD_COUNT, MISS_COUNT);
        end
        step(0, 1, 5, 0, 0, 0, 0, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b100) begin
            errors++;
            $display("FAIL lookup_after_reset got %b want 100", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
    endtask

    task automatic test_update;
        step(0, 0, 0, 1, 2, 1, 1, 0);
        checks++;
        if (PRED_OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL idle_out_valid got %b want 0", PRED_OUT_VALID);
        end
        step(0, 1, 2, 0, 0, 0, 0, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b111) begin
            errors++;
            $display("FAIL update_hit_addr2 got %b want 111", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
        step(0, 1, 3, 0, 0, 0, 0, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b100) begin
            errors++;
            $display("FAIL miss_addr3 got %b want 100", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
    endtask

    task automatic test_bypass;
        step(0, 1, 6, 1, 6, 1, 0, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b111) begin
            errors++;
            $display("FAIL bypass_taken got %b want 111", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
        // No lookup: valid drops, prediction and hit hold.
        step(0, 0, 0, 1, 6, 0, 1, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b011) begin
            errors++;
            $display("FAIL hold_outputs got %b want 011", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
        step(0, 1, 6, 0, 0, 0, 0, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b101) begin
            errors++;
            $display("FAIL retrain_not_taken got %b want 101", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
    endtask

    task automatic test_invalidate;
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, i, 1, 0, 0);
        // Same-cycle lookup of entry 0 still sees pre-invalidate state.
        step(0, 1, 0, 1, 4, 1, 0, 1);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b111) begin
            errors++;
            $display("FAIL inval_same_cycle_lookup got %b want 111", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic [2:0] want;
            want = (i == 4) ? 3'b111 : 3'b100;
            step(0, 1, i, 0, 0, 0, 0, 0);
            checks++;
            if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== want) begin
                errors++;
                $display("FAIL inval_lookup_%0d got %b want %b", i, {PRED_OUT_VALID, PREDICTION, PRED_HIT}, want);
            end
        end
    endtask

    task automatic test_reset_mid;
        step(0, 1, 1, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1, 1, 1, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b000 || UPD_COUNT !== '0 || MISS_COUNT !== '0) begin
            errors++;
            $display("FAIL reset_overrides got %b cnt %0d/%0d want 000 0/0",
                     {PRED_OUT_VALID, PREDICTION, PRED_HIT}, UPD_COUNT, MISS_COUNT);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle got %b want 000", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
        step(0, 1, 1, 0, 0, 0, 0, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_addr1 got %b want 100", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
    endtask

    task automatic test_idle_x;
        step(0, 0, 0, 1, 7, 1, 0, 0);
        step(0, 0, 0, 0, 7, 1'bx, 1'bx, 0);
        step(0, 1, 7, 0, 0, 0, 0, 0);
        checks++;
        if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== 3'b111) begin
            errors++;
            $display("FAIL idle_x_no_corrupt got %b want 111", {PRED_OUT_VALID, PREDICTION, PRED_HIT});
        end
    endtask

    task automatic test_stats;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, i, i[0], (i < 17) ? 1'b1 : 1'b0, 0);
`ifdef BHT_STATS_EN
        checks++;
        if (UPD_COUNT !== 4'd15 || MISS_COUNT !== 4'd15) begin
            errors++;
            $display("FAIL stats_saturate got upd=%0d miss=%0d want 15 15", UPD_COUNT, MISS_COUNT);
        end
`else
        checks++;
        if (UPD_COUNT !== '0 || MISS_COUNT !== '0) begin
            errors++;
            $display("FAIL stats_tied_off got upd=%0d miss=%0d want 0 0", UPD_COUNT, MISS_COUNT);
        end
`endif
        step(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (UPD_COUNT !== m_upd || MISS_COUNT !== m_miss) begin
            errors++;
            $display("FAIL stats_after_inval got upd=%0d miss=%0d want %0d %0d", UPD_COUNT, MISS_COUNT, m_upd, m_miss);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (UPD_COUNT !== '0 || MISS_COUNT !== '0) begin
            errors++;
            $display("FAIL stats_reset got upd=%0d miss=%0d want 0 0", UPD_COUNT, MISS_COUNT);
        end
    endtask

    task automatic test_random;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            logic rst, inv;
            rst = ($urandom_range(99) < 2);
            inv = ($urandom_range(99) < 4);
            step(rst, 1'($urandom), int'($urandom_range(DEPTH - 1)),
                 1'($urandom), int'($urandom_range(DEPTH - 1)),
                 1'($urandom), 1'($urandom), inv);
            checks++;
            if ({PRED_OUT_VALID, PREDICTION, PRED_HIT} !== m_out || UPD_COUNT !== m_upd || MISS_COUNT !== m_miss) begin
                errors++;
                $display("FAIL random_cycle_%0d got %b cnt %0d/%0d want %b cnt %0d/%0d", n,
                         {PRED_OUT_VALID, PREDICTION, PRED_HIT}, UPD_COUNT, MISS_COUNT,
                         m_out, m_upd, m_miss);
            end
        end
    endtask

    initial begin
        RESET = 1'b1; PRED_VALID = 1'b0; PRED_ADDR = '0; UPD_VALID = 1'b0;
        UPD_ADDR = '0; OUTCOME = 1'b0; MISS = 1'b0; INVALIDATE = 1'b0;
        m_out = 3'b000; m_upd = '0; m_miss = '0;
        @(posedge CLK);
        #1;
        test_reset;
        test_update;
        test_bypass;
        test_invalidate;
        test_reset_mid;
        test_idle_x;
        test_stats;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bht_1bit_table.md
Name: bht_1bit_table

Overview:
- Branch history table of 1-bit predictors. Sits directly downstream of the 1-bit outcome/miss demultiplexer and holds the per-entry predictor state that the demux steers updates into.
- The IF stage reads a registered taken/not-taken prediction indexed by low PC bits.
- The EX stage writes back resolved branch outcome and miss flags.
- Provides same-cycle write-to-read bypass, bulk invalidate, and optional miss statistics.

Parameters:
- IDX_W, 3, index width; table depth = 2**IDX_W entries (3 matches the demux ADDR width).
- CNT_W, 16, width of statistics counters (used only with BHT_STATS_EN).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- PRED_VALID  input  1  IF-stage lookup request this cycle.
- PRED_ADDR  input  IDX_W  lookup index (PC[IDX_W+1:2]).
- PRED_OUT_VALID  output  1  registered: lookup result valid.
- PREDICTION  output  1  registered: 1 = predict taken.
- PRED_HIT  output  1  registered: indexed entry was valid at lookup.
- UPD_VALID  input  1  EX-stage resolved-branch update strobe.
- UPD_ADDR  input  IDX_W  index of resolved branch.
- OUTCOME  input  1  resolved direction, 1 = taken.
- MISS  input  1  resolved branch was mispredicted.
- INVALIDATE  input  1  clear all entry valid bits (context switch / fence.i).
- MISS_COUNT  output  CNT_W  mispredict counter (BHT_STATS_EN only).
- UPD_COUNT  output  CNT_W  update counter (BHT_STATS_EN only).

Behaviour:
- Storage: DEPTH state bits st[i] and DEPTH valid bits v[i], all registers (no RAM macro).
- Reset: st, v, PRED_OUT_VALID, PREDICTION, PRED_HIT and the counters all go to 0 on the CLK edge while RESET=1. RESET overrides every other input, including a pending update or lookup. Outputs are 0 the cycle after RESET is deasserted.
- Lookup:
  - Latency 1. On edge with PRED_VALID=1, PRED_OUT_VALID<=1, PREDICTION<=v[PRED_ADDR]&st[PRED_ADDR], PRED_HIT<=v[PRED_ADDR].
  - With PRED_VALID=0: PRED_OUT_VALID<=0 and PREDICTION/PRED_HIT hold their previous values.
- Update:
  - On edge with UPD_VALID=1: st[UPD_ADDR]<=OUTCOME, v[UPD_ADDR]<=1.
  - MISS does not alter the state write (1-bit scheme: the state always takes the last outcome). MISS is consumed only by statistics.
  - MISS=1 with OUTCOME equal to the stored state is legal and is still counted.
- Bypass: when PRED_VALID & UPD_VALID & PRED_ADDR==UPD_ADDR in the same cycle, the registered result uses the new value: PREDICTION<=OUTCOME, PRED_HIT<=1.
- Invalidate:
  - On edge with INVALIDATE=1, all v<=0; st is untouched.
  - If UPD_VALID is also 1, the update wins for UPD_ADDR only (v[UPD_ADDR]<=1, st written); all other entries are invalidated.
  - A lookup in the same cycle sees pre-invalidate state, with bypass still applied.
- Invalid entries always predict not-taken (PREDICTION=0, PRED_HIT=0).
- Indices wrap naturally within IDX_W; no out-of-range case exists.
- Behaviour with X on OUTCOME/MISS while UPD_VALID=0 is don't-care and must not corrupt state.

Optional Feature:
- Macro BHT_STATS_EN.
- Defined:
  - UPD_COUNT increments on every edge with UPD_VALID=1.
  - MISS_COUNT increments on every edge with UPD_VALID&MISS=1.
  - Both saturate at 2**CNT_W-1 (no wrap), clear on RESET, and are unaffected by INVALIDATE.
- Undefined: MISS_COUNT and UPD_COUNT are tied to 0, no counter flops are inferred, and MISS is unused.

Test Plan:
- Reset, then PRED_VALID=1 with PRED_ADDR=5 -> next cycle PRED_OUT_VALID=1, PREDICTION=0, PRED_HIT=0.
- UPD_VALID=1, UPD_ADDR=2, OUTCOME=1, MISS=1; then lookup addr 2 -> PREDICTION=1, PRED_HIT=1. Lookup addr 3 -> PREDICTION=0, PRED_HIT=0.
- Same cycle: UPD addr 6 with OUTCOME=1 plus PRED addr 6 -> next cycle PREDICTION=1, PRED_HIT=1 (bypass). Then UPD addr 6 with OUTCOME=0 -> following lookup PREDICTION=0, PRED_HIT=1.
- Fill entries 0..7 with OUTCOME=1, then INVALIDATE=1 together with UPD addr 4, OUTCOME=1 -> lookups of 0..7 give PREDICTION=1 only at addr 4 and 0 elsewhere.
- Assert RESET during back-to-back updates to addr 1 -> all state and outputs 0. The first lookup of addr 1 after reset gives PREDICTION=0.
- With BHT_STATS_EN and CNT_W=4: 20 updates, 17 of them with MISS=1 -> UPD_COUNT=15 and MISS_COUNT=15 (saturated). RESET -> both 0.
